// File: rtl/spi_flash_rd_ctrl.sv
// Sequencer for the byte-wide SPI master that performs READ (opcode + 24-bit address + data) from serial NOR flash.
// The controller owns the flash chip select and holds it low across the whole multi-byte transaction.
module spi_flash_rd_ctrl #(
    parameter logic [7:0]  CMD_READ  = 8'h03,
    parameter bit          WAKE_EN   = 1'b1,
    parameter logic [7:0]  WAKE_CMD  = 8'hAB,
    parameter int unsigned WAKE_WAIT = 40,
    parameter int unsigned CS_GAP    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [23:0] req_addr,
    input  logic [15:0] req_len,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    output logic        done,
    output logic        busy,
    output logic        flash_cs_n,
    output logic        spi_start,
    output logic [7:0]  spi_din,
    input  logic        spi_busy,
    input  logic        spi_done,
    input  logic [7:0]  spi_dout,
    output logic        spi_cpol,
    output logic        spi_cpha,
    output logic        spi_msbfirst
);

    typedef enum logic [3:0] {
        ST_WAKE, ST_WAKE_WAIT, ST_IDLE, ST_CMD, ST_A2, ST_A1, ST_A0, ST_DATA, ST_GAP
    } state_t;

    // Sub-phases of every byte state: drop CS, issue start, wait for done, capture the result.
    typedef enum logic [1:0] {PH_CS, PH_ISSUE, PH_WAIT, PH_CAP} phase_t;

    localparam state_t      RESET_STATE = WAKE_EN ? ST_WAKE : ST_IDLE;
    localparam logic [15:0] WAKE_LOAD   = 16'(WAKE_WAIT - 1);
    localparam logic [15:0] GAP_LOAD    = 16'(CS_GAP - 1);

    state_t      state_r, state_s;
    phase_t      phase_r, phase_s;
    logic [23:0] addr_r, addr_s;
    logic [15:0] remain_r, remain_s;
    logic [15:0] wait_r, wait_s;
    logic        cs_n_r, cs_n_s;
    logic        start_r, start_s;
    logic [7:0]  din_r, din_s;
    logic [7:0]  rd_data_r, rd_data_s;
    logic        rd_valid_r, rd_valid_s;
    logic        done_r, done_s;
    logic        busy_r, busy_s;
    logic        ready_r, ready_s;

    function automatic logic [7:0] tx_byte(input state_t st, input logic [23:0] addr);
        case (st)
            ST_WAKE: tx_byte = WAKE_CMD;
            ST_CMD:  tx_byte = CMD_READ;
            ST_A2:   tx_byte = addr[23:16];
            ST_A1:   tx_byte = addr[15:8];
            ST_A0:   tx_byte = addr[7:0];
            default: tx_byte = 8'h00;
        endcase
    endfunction

    function automatic state_t header_next(input state_t st);
        case (st)
            ST_CMD:  header_next = ST_A2;
            ST_A2:   header_next = ST_A1;
            ST_A1:   header_next = ST_A0;
            default: header_next = ST_DATA;
        endcase
    endfunction

    // Next-state and next-output logic; all outputs are registered from these values.
    always_comb begin
        state_s    = state_r;
        phase_s    = phase_r;
        addr_s     = addr_r;
        remain_s   = remain_r;
        wait_s     = wait_r;
        cs_n_s     = cs_n_r;
        start_s    = 1'b0;
        din_s      = din_r;
        rd_data_s  = rd_data_r;
        rd_valid_s = 1'b0;
        done_s     = 1'b0;
        case (state_r)
            ST_WAKE_WAIT, ST_GAP: begin
                if (wait_r == 16'd0) begin
                    state_s = ST_IDLE;
                end else begin
                    wait_s = wait_r - 16'd1;
                end
            end
            ST_IDLE: begin
                if (req_valid && ready_r) begin
                    addr_s   = req_addr;
                    remain_s = req_len;
                    if (req_len == 16'd0) begin
                        done_s = 1'b1;
                    end else begin
                        cs_n_s  = 1'b0;
                        state_s = ST_CMD;
                        phase_s = PH_ISSUE;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            default: begin
                case (phase_r)
                    PH_CS: begin
                        cs_n_s  = 1'b0;
                        phase_s = PH_ISSUE;
                    end
                    PH_ISSUE: begin
                        if (!spi_busy) begin
                            start_s = 1'b1;
                            din_s   = tx_byte(state_r, addr_r);
                            phase_s = PH_WAIT;
                        end else begin
                            phase_s = PH_ISSUE;
                        end
                    end
                    PH_WAIT: begin
                        if (spi_done) begin
                            phase_s = PH_CAP;
                        end else begin
                            phase_s = PH_WAIT;
                        end
                    end
                    PH_CAP: begin
                        // spi_dout is valid here: the master loaded it on the done edge.
                        phase_s = PH_ISSUE;
                        if (state_r == ST_WAKE) begin
                            cs_n_s  = 1'b1;
                            state_s = ST_WAKE_WAIT;
                            wait_s  = WAKE_LOAD;
                        end else if (state_r == ST_DATA) begin
                            rd_data_s  = spi_dout;
                            rd_valid_s = 1'b1;
                            remain_s   = remain_r - 16'd1;
                            if (remain_r == 16'd1) begin
                                cs_n_s  = 1'b1;
                                done_s  = 1'b1;
                                state_s = ST_GAP;
                                wait_s  = GAP_LOAD;
                            end else begin
                                state_s = ST_DATA;
                            end
                        end else begin
                            state_s = header_next(state_r);
                        end
                    end
                    default: phase_s = PH_ISSUE;
                endcase
            end
        endcase
        busy_s  = (state_s != ST_IDLE);
        ready_s = (state_s == ST_IDLE);
    end

    // State and output registers; reset abandons any transfer in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= RESET_STATE;
            phase_r    <= PH_CS;
            addr_r     <= 24'd0;
            remain_r   <= 16'd0;
            wait_r     <= 16'd0;
            cs_n_r     <= 1'b1;
            start_r    <= 1'b0;
            din_r      <= 8'h00;
            rd_data_r  <= 8'h00;
            rd_valid_r <= 1'b0;
            done_r     <= 1'b0;
            busy_r     <= WAKE_EN ? 1'b1 : 1'b0;
            ready_r    <= WAKE_EN ? 1'b0 : 1'b1;
        end else begin
            state_r    <= state_s;
            phase_r    <= phase_s;
            addr_r     <= addr_s;
            remain_r   <= remain_s;
            wait_r     <= wait_s;
            cs_n_r     <= cs_n_s;
            start_r    <= start_s;
            din_r      <= din_s;
            rd_data_r  <= rd_data_s;
            rd_valid_r <= rd_valid_s;
            done_r     <= done_s;
            busy_r     <= busy_s;
            ready_r    <= ready_s;
        end
    end

    assign req_ready    = ready_r;
    assign rd_data      = rd_data_r;
    assign rd_valid     = rd_valid_r;
    assign done         = done_r;
    assign busy         = busy_r;
    assign flash_cs_n   = cs_n_r;
    assign spi_start    = start_r;
    assign spi_din      = din_r;
    assign spi_cpol     = 1'b0;
    assign spi_cpha     = 1'b0;
    assign spi_msbfirst = 1'b1;

endmodule

// File: tb/tb_spi_flash_rd_ctrl.sv
// Directed scoreboard bench: a behavioural SPI master + flash model checks MOSI bytes and returned read data.
module tb_spi_flash_rd_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid, req_ready;
    logic [23:0] req_addr;
    logic [15:0] req_len;
    logic [7:0]  rd_data;
    logic        rd_valid, done, busy, flash_cs_n, spi_start;
    logic [7:0]  spi_din;
    logic        spi_busy, spi_done;
    logic [7:0]  spi_dout;
    logic        spi_cpol, spi_cpha, spi_msbfirst;

    int checks = 0;
    int failures = 0;

    logic [7:0] exp_mosi[$];
    logic [7:0] exp_rd[$];
    logic [7:0] rsp_q[$];

    int         n_start = 0, n_rdv = 0, n_done = 0, n_cs_fall = 0, cs_idx = 0;
    logic       prev_cs_n = 1'b1;
    logic [7:0] m_rsp = 8'hFF;
    logic [7:0] m_byte;
    logic [3:0] m_cnt;

    spi_flash_rd_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
        .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .busy(busy),
        .flash_cs_n(flash_cs_n), .spi_start(spi_start), .spi_din(spi_din),
        .spi_busy(spi_busy), .spi_done(spi_done), .spi_dout(spi_dout),
        .spi_cpol(spi_cpol), .spi_cpha(spi_cpha), .spi_msbfirst(spi_msbfirst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // SPI master model: 8-cycle byte, buffer updated on the done edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spi_busy <= 1'b0;
            spi_done <= 1'b0;
            spi_dout <= 8'h00;
            m_cnt    <= 4'd0;
            m_byte   <= 8'h00;
        end else begin
            spi_done <= 1'b0;
            if (!spi_busy && spi_start) begin
                spi_busy <= 1'b1;
                m_cnt    <= 4'd6;
                m_byte   <= m_rsp;
            end else if (spi_busy) begin
                if (m_cnt == 4'd0) begin
                    spi_busy <= 1'b0;
                    spi_done <= 1'b1;
                    spi_dout <= m_byte;
                end else begin
                    m_cnt <= m_cnt - 4'd1;
                end
            end
        end
    end

    // Flash-side monitor: MOSI scoreboard, data-phase responses, read-data scoreboard.
    always @(negedge clk) begin
        prev_cs_n <= flash_cs_n;
        if (prev_cs_n && !flash_cs_n) n_cs_fall <= n_cs_fall + 1;
        if (flash_cs_n) cs_idx <= 0;
        if (spi_start) begin
            n_start <= n_start + 1;
            cs_idx  <= cs_idx + 1;
            chk("cs_low_before_start", {31'd0, prev_cs_n}, 32'd0);
            chk("start_while_idle", {31'd0, spi_busy}, 32'd0);
            if (exp_mosi.size() == 0) chk("mosi_unexpected", exp_mosi.size(), 32'd1);
            else chk("mosi", {24'd0, spi_din}, {24'd0, exp_mosi.pop_front()});
            if (cs_idx >= 4 && rsp_q.size() > 0) m_rsp <= rsp_q.pop_front();
            else m_rsp <= 8'hFF;
        end
        if (rd_valid) begin
            n_rdv <= n_rdv + 1;
            if (exp_rd.size() == 0) chk("rd_unexpected", exp_rd.size(), 32'd1);
            else chk("rd_data", {24'd0, rd_data}, {24'd0, exp_rd.pop_front()});
        end
        if (done) n_done <= n_done + 1;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int c;
        c = 0;
        while (!req_ready && c < 500) begin
            step();
            c++;
        end
        chk("ready_seen", {31'd0, req_ready}, 32'd1);
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (!done && cyc < 2000);
        chk("done_seen", {31'd0, done}, 32'd1);
    endtask

    task automatic push_read(input logic [23:0] a, input logic [15:0] n, input logic [7:0] base);
        exp_mosi.push_back(8'h03);
        exp_mosi.push_back(a[23:16]);
        exp_mosi.push_back(a[15:8]);
        exp_mosi.push_back(a[7:0]);
        for (int i = 0; i < int'(n); i++) begin
            exp_mosi.push_back(8'h00);
            rsp_q.push_back(base + 8'(i));
            exp_rd.push_back(base + 8'(i));
        end
    endtask

    task automatic txn(input logic [23:0] a, input logic [15:0] n, input logic [7:0] base);
        int s_start, s_rdv, s_fall, s_done, cyc, gap;
        wait_ready();
        s_start = n_start; s_rdv = n_rdv; s_fall = n_cs_fall; s_done = n_done;
        if (n != 16'd0) push_read(a, n, base);
        req_addr  = a;
        req_len   = n;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        wait_done(cyc);
        if (n == 16'd0) chk("len0_done_latency", cyc, 32'd1);
        chk("rd_valid_with_done", {31'd0, rd_valid}, {31'd0, n != 16'd0});
        chk("cs_high_at_done", {31'd0, flash_cs_n}, 32'd1);
        gap = 0;
        while (!req_ready && gap < 50) begin
            step();
            gap++;
        end
        chk("gap_cycles", gap, (n == 16'd0) ? 32'd0 : 32'd2);
        chk("start_count", n_start - s_start, (n == 16'd0) ? 32'd0 : 32'd4 + 32'(n));
        chk("cs_fall_count", n_cs_fall - s_fall, (n == 16'd0) ? 32'd0 : 32'd1);
        chk("rd_valid_count", n_rdv - s_rdv, 32'(n));
        chk("done_count", n_done - s_done, 32'd1);
        chk("mosi_left", exp_mosi.size(), 32'd0);
        chk("rd_left", exp_rd.size(), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, hi, lo_seen, s_start, s_rdv, s_fall, s_done;
        rst_n = 1'b0; req_valid = 1'b0; req_addr = 24'd0; req_len = 16'd0;
        repeat (3) step();
        chk("rst_cs_n", {31'd0, flash_cs_n}, 32'd1);
        chk("rst_start", {31'd0, spi_start}, 32'd0);
        chk("rst_din", {24'd0, spi_din}, 32'd0);
        chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_rd_data", {24'd0, rd_data}, 32'd0);
        chk("rst_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd1);
        chk("mode_pins", {29'd0, spi_cpol, spi_cpha, spi_msbfirst}, 32'd1);

        // Wake sequence: one 0xAB byte, then CS held high for at least 40 cycles.
        exp_mosi.push_back(8'hAB);
        rst_n = 1'b1;
        cyc = 0;
        while (flash_cs_n && cyc < 100) begin step(); cyc++; end
        chk("wake_cs_low", {31'd0, flash_cs_n}, 32'd0);
        cyc = 0;
        while (!flash_cs_n && cyc < 200) begin step(); cyc++; end
        chk("wake_cs_release", {31'd0, flash_cs_n}, 32'd1);
        hi = 0; lo_seen = 0;
        while (!req_ready && hi < 500) begin
            step();
            hi++;
            if (!flash_cs_n) lo_seen++;
        end
        chk("wake_wait_min", {31'd0, hi >= 40}, 32'd1);
        chk("wake_cs_held_high", lo_seen, 32'd0);
        chk("wake_start_count", n_start, 32'd1);
        chk("wake_no_rd_valid", n_rdv, 32'd0);
        chk("wake_no_done", n_done, 32'd0);
        chk("wake_busy_low", {31'd0, busy}, 32'd0);
        chk("wake_mosi_left", exp_mosi.size(), 32'd0);

        txn(24'h123456, 16'd1, 8'h5A);
        txn(24'h000100, 16'd4, 8'hA0);
        txn(24'h000400, 16'd0, 8'h00);

        // req_valid held through a burst with a new address: taken only after the gap.
        wait_ready();
        s_start = n_start; s_fall = n_cs_fall; s_done = n_done;
        push_read(24'h000200, 16'd2, 8'h20);
        push_read(24'hABCDEF, 16'd1, 8'h77);
        req_addr = 24'h000200; req_len = 16'd2; req_valid = 1'b1;
        @(posedge clk);
        #1 begin req_addr = 24'hABCDEF; req_len = 16'd1; end
        wait_done(cyc);
        wait_ready();
        @(posedge clk);
        #1 req_valid = 1'b0;
        wait_done(cyc);
        chk("held_done_count", n_done - s_done, 32'd2);
        chk("held_start_count", n_start - s_start, 32'd11);
        chk("held_cs_falls", n_cs_fall - s_fall, 32'd2);
        chk("held_mosi_left", exp_mosi.size(), 32'd0);
        chk("held_rd_left", exp_rd.size(), 32'd0);

        // Reset during the second data byte of a 4-byte read.
        wait_ready();
        s_rdv = n_rdv;
        push_read(24'h000300, 16'd4, 8'hC0);
        req_addr = 24'h000300; req_len = 16'd4; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        cyc = 0;
        while (n_rdv == s_rdv && cyc < 500) begin step(); cyc++; end
        chk("abort_first_byte", n_rdv - s_rdv, 32'd1);
        s_start = n_start;
        cyc = 0;
        while (n_start == s_start && cyc < 100) begin step(); cyc++; end
        chk("abort_second_start", n_start - s_start, 32'd1);
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("abort_cs_n", {31'd0, flash_cs_n}, 32'd1);
        chk("abort_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd1);
        exp_mosi.delete();
        exp_rd.delete();
        rsp_q.delete();
        exp_mosi.push_back(8'hAB);
        s_done = n_done; s_start = n_start;
        step();
        step();
        rst_n = 1'b1;
        wait_ready();
        chk("abort_no_done", n_done - s_done, 32'd0);
        chk("abort_wake_replay", n_start - s_start, 32'd1);
        chk("abort_mosi_left", exp_mosi.size(), 32'd0);

        // Read across the top of the address space; the flash wraps on its own.
        txn(24'hFFFFFE, 16'd2, 8'h11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
